ann_input_feeder: RTL and testbench
===================================

ANN_INPUT_FEEDER -- requirements
Module: ann_input_feeder

Interface
REQ-001 Parameter NUM_PIX, default 16, number of pixels per image (power of 2 not required, >=2).
REQ-002 Parameter NUM_COEFF, default 8, number of coefficients per pass (>=2).
REQ-003 Parameter DATA_W, default 8, width of pixel and coefficient words.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 rx_data  input  DATA_W  host load word (pixels first, then coefficients).
REQ-007 rx_valid  input  1  host word valid.
REQ-008 rx_ready  output  1  block accepts host word this cycle.
REQ-009 request  input  1  single-cycle pulse from ANN controller: start serving a pass.
REQ-010 load_next  input  1  controller pulse: advance pixel index.
REQ-011 next_coeff  input  1  controller pulse: advance coefficient index.
REQ-012 done  input  1  controller pulse: pass finished, release buffer.
REQ-013 image_loaded  output  1  full image and coefficient set buffered, not yet served.
REQ-014 data_valid  output  1  pixel_out/coeff_out valid (SERVE state).
REQ-015 pixel_out  output  DATA_W  pixel at current pixel index.
REQ-016 coeff_out  output  DATA_W  coefficient at current coefficient index.
REQ-017 last_pixel  output  1  current pixel index == NUM_PIX-1 and data_valid.
REQ-018 last_coeff  output  1  current coefficient index == NUM_COEFF-1 and data_valid.

Function
REQ-019 The block SHALL implement states FILL_PIX, FILL_COEFF, LOADED, SERVE with a registered state.
REQ-020 FILL_PIX: rx_ready=1; each rx_valid&rx_ready beat SHALL write rx_data to pixel buffer at wr_idx and increment wr_idx.
REQ-021 The NUM_PIX-th accepted pixel SHALL move state to FILL_COEFF and clear wr_idx on the same edge.
REQ-022 FILL_COEFF: rx_ready=1; beats SHALL write the coefficient buffer; the NUM_COEFF-th beat SHALL move to LOADED and clear wr_idx.
REQ-023 rx_ready SHALL be 0 in LOADED and SERVE; rx_valid there SHALL be ignored with no buffer write.
REQ-024 LOADED: image_loaded=1 (combinational from state); request SHALL move to SERVE, clearing pix_idx and coeff_idx.
REQ-025 SERVE: data_valid=1, image_loaded=0; pixel_out=pix_buf[pix_idx], coeff_out=coeff_buf[coeff_idx] (combinational read of registered index).
REQ-026 Latency: data_valid and index-0 data SHALL appear the cycle after request is sampled; new data SHALL appear the cycle after load_next/next_coeff is sampled.
REQ-027 load_next in SERVE SHALL increment pix_idx, wrapping NUM_PIX-1 -> 0.
REQ-028 next_coeff in SERVE SHALL increment coeff_idx, wrapping NUM_COEFF-1 -> 0.
REQ-029 Simultaneous load_next and next_coeff SHALL advance both indices on the same edge.
REQ-030 done in SERVE SHALL move to FILL_PIX, clear all indices, and take priority over simultaneous load_next/next_coeff.
REQ-031 request outside LOADED, done outside SERVE, load_next/next_coeff outside SERVE SHALL be ignored.
REQ-032 When data_valid=0, pixel_out, coeff_out, last_pixel, last_coeff SHALL be 0.
REQ-033 Buffer contents SHALL persist until overwritten by the next fill; re-serving requires a full refill.

Reset
REQ-034 n_rst low SHALL immediately force state FILL_PIX, wr_idx/pix_idx/coeff_idx=0, regardless of clock.
REQ-035 Reset values: rx_ready=1, image_loaded=0, data_valid=0, pixel_out=0, coeff_out=0, last_pixel=0, last_coeff=0.
REQ-036 Reset mid-fill or mid-serve SHALL discard the partial image; buffer storage need not be cleared.

Verification
REQ-037 Fill: reset, stream pixels 1..16 then coeffs 0xA0..0xA7 with rx_valid held -> rx_ready drops after 24th beat, image_loaded=1 next cycle.
REQ-038 Backpressure gaps: rx_valid toggled 0/1 during fill -> only valid beats written, image_loaded after exactly 24 accepted beats.
REQ-039 Serve: request -> next cycle data_valid=1, pixel_out=1, coeff_out=0xA0; 15 load_next pulses -> pixel_out=16, last_pixel=1; one more -> pixel_out=1, last_pixel=0.
REQ-040 Simultaneous load_next+next_coeff at coeff index 7 -> coeff_out=0xA0 (wrap), pixel index advanced by one.
REQ-041 done with load_next same cycle -> state FILL_PIX, data_valid=0, outputs 0, rx_ready=1; request then ignored until refill.
REQ-042 n_rst asserted mid-SERVE between clock edges -> outputs at reset values immediately; image_loaded=0 until a new 24-beat fill completes.

Source files
------------

// File: rtl/ann_input_feeder_if.sv
// rtl/ann_input_feeder_if.sv - host load stream and ANN controller serve bus
// Signals:
//   rx_data/rx_valid/rx_ready       host load stream (pixels, then coefficients)
//   request/load_next/next_coeff/done  controller pulses
//   image_loaded/data_valid          buffer status
//   pixel_out/coeff_out              served words
//   last_pixel/last_coeff            index-at-end flags
// slave = feeder side, master = host/controller side.
interface ann_input_feeder_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              request;
  logic              load_next;
  logic              next_coeff;
  logic              done;
  logic              image_loaded;
  logic              data_valid;
  logic [DATA_W-1:0] pixel_out;
  logic [DATA_W-1:0] coeff_out;
  logic              last_pixel;
  logic              last_coeff;

  modport slave (
    input  rx_data, rx_valid, request, load_next, next_coeff, done,
    output rx_ready, image_loaded, data_valid, pixel_out, coeff_out,
           last_pixel, last_coeff
  );

  modport master (
    output rx_data, rx_valid, request, load_next, next_coeff, done,
    input  rx_ready, image_loaded, data_valid, pixel_out, coeff_out,
           last_pixel, last_coeff
  );
endinterface

// File: rtl/ann_input_feeder.sv
// rtl/ann_input_feeder.sv - buffers one image plus coefficient set and serves it to an ANN controller
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    ann_input_feeder_if.slave (load stream, controller pulses, served data)
// Flow: FILL_PIX -> FILL_COEFF -> LOADED -> (request) SERVE -> (done) FILL_PIX.
module ann_input_feeder #(
  parameter int NUM_PIX   = 16,
  parameter int NUM_COEFF = 8,
  parameter int DATA_W    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  ann_input_feeder_if.slave    bus
);

  localparam int PIX_AW   = (NUM_PIX   > 1) ? $clog2(NUM_PIX)   : 1;
  localparam int COEFF_AW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam int WR_AW    = (PIX_AW > COEFF_AW) ? PIX_AW : COEFF_AW;

  localparam logic [PIX_AW-1:0]   PIX_LAST      = PIX_AW'(NUM_PIX - 1);
  localparam logic [COEFF_AW-1:0] COEFF_LAST    = COEFF_AW'(NUM_COEFF - 1);
  localparam logic [WR_AW-1:0]    WR_PIX_LAST   = WR_AW'(NUM_PIX - 1);
  localparam logic [WR_AW-1:0]    WR_COEFF_LAST = WR_AW'(NUM_COEFF - 1);

  typedef enum logic [1:0] {
    FILL_PIX   = 2'd0,
    FILL_COEFF = 2'd1,
    LOADED     = 2'd2,
    SERVE      = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WR_AW-1:0]    wr_idx_q, wr_idx_d;
  logic [PIX_AW-1:0]   pix_idx_q, pix_idx_d;
  logic [COEFF_AW-1:0] coeff_idx_q, coeff_idx_d;

  logic [DATA_W-1:0] pix_buf_q   [NUM_PIX];
  logic [DATA_W-1:0] coeff_buf_q [NUM_COEFF];

  logic pix_we;
  logic coeff_we;
  logic rx_ready;
  logic data_valid;

  assign rx_ready   = (state_q == FILL_PIX) || (state_q == FILL_COEFF);
  assign data_valid = (state_q == SERVE);

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    pix_idx_d   = pix_idx_q;
    coeff_idx_d = coeff_idx_q;
    pix_we      = 1'b0;
    coeff_we    = 1'b0;

    case (state_q)
      FILL_PIX: begin
        if (bus.rx_valid) begin
          pix_we = 1'b1;
          if (wr_idx_q == WR_PIX_LAST) begin
            state_d  = FILL_COEFF;
            wr_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + WR_AW'(1);
          end
        end
      end

      FILL_COEFF: begin
        if (bus.rx_valid) begin
          coeff_we = 1'b1;
          if (wr_idx_q == WR_COEFF_LAST) begin
            state_d  = LOADED;
            wr_idx_d = '0;
          end else begin
            wr_idx_d = wr_idx_q + WR_AW'(1);
          end
        end
      end

      LOADED: begin
        if (bus.request) begin
          state_d     = SERVE;
          pix_idx_d   = '0;
          coeff_idx_d = '0;
        end
      end

      SERVE: begin
        // done wins over any index advance in the same cycle
        if (bus.done) begin
          state_d     = FILL_PIX;
          wr_idx_d    = '0;
          pix_idx_d   = '0;
          coeff_idx_d = '0;
        end else begin
          if (bus.load_next) begin
            pix_idx_d = (pix_idx_q == PIX_LAST) ? '0 : pix_idx_q + PIX_AW'(1);
          end
          if (bus.next_coeff) begin
            coeff_idx_d = (coeff_idx_q == COEFF_LAST) ? '0 : coeff_idx_q + COEFF_AW'(1);
          end
        end
      end

      default: begin
        state_d     = FILL_PIX;
        wr_idx_d    = '0;
        pix_idx_d   = '0;
        coeff_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= FILL_PIX;
      wr_idx_q    <= '0;
      pix_idx_q   <= '0;
      coeff_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      pix_idx_q   <= pix_idx_d;
      coeff_idx_q <= coeff_idx_d;
    end
  end

  // Storage is not reset: a reset only discards the fill progress, and
  // LOADED cannot be reached again without overwriting every entry.
  always_ff @(posedge clk) begin
    if (pix_we) begin
      pix_buf_q[wr_idx_q[PIX_AW-1:0]] <= bus.rx_data;
    end
    if (coeff_we) begin
      coeff_buf_q[wr_idx_q[COEFF_AW-1:0]] <= bus.rx_data;
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.image_loaded = (state_q == LOADED);
  assign bus.data_valid   = data_valid;
  assign bus.pixel_out    = data_valid ? pix_buf_q[pix_idx_q] : '0;
  assign bus.coeff_out    = data_valid ? coeff_buf_q[coeff_idx_q] : '0;
  assign bus.last_pixel   = data_valid && (pix_idx_q == PIX_LAST);
  assign bus.last_coeff   = data_valid && (coeff_idx_q == COEFF_LAST);

endmodule

// File: tb/tb_ann_input_feeder.sv
// tb/tb_ann_input_feeder.sv - directed self-checking bench for ann_input_feeder
module tb_ann_input_feeder;

  localparam int NUM_PIX   = 16;
  localparam int NUM_COEFF = 8;
  localparam int DATA_W    = 8;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_pass;

  ann_input_feeder_if #(.DATA_W(DATA_W)) bus ();

  ann_input_feeder #(
    .NUM_PIX   (NUM_PIX),
    .NUM_COEFF (NUM_COEFF),
    .DATA_W    (DATA_W)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // inputs change and outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    bus.request    = 1'b0;
    bus.load_next  = 1'b0;
    bus.next_coeff = 1'b0;
    bus.done       = 1'b0;
  endtask

  task automatic pulse_request();
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
  endtask

  task automatic pulse_adv(input logic ln, input logic nc, input logic dn);
    bus.load_next  = ln;
    bus.next_coeff = nc;
    bus.done       = dn;
    tick();
    bus.load_next  = 1'b0;
    bus.next_coeff = 1'b0;
    bus.done       = 1'b0;
  endtask

  initial begin
    int accepted;
    int cyc;
    n_checks = 0;
    n_pass   = 0;
    idle_inputs();
    n_rst = 1'b0;
    #2;
    check("rst_rx_ready",     32'(bus.rx_ready),     32'd1);
    check("rst_image_loaded", 32'(bus.image_loaded), 32'd0);
    check("rst_data_valid",   32'(bus.data_valid),   32'd0);
    check("rst_pixel_out",    32'(bus.pixel_out),    32'd0);
    check("rst_coeff_out",    32'(bus.coeff_out),    32'd0);
    check("rst_last_pixel",   32'(bus.last_pixel),   32'd0);
    check("rst_last_coeff",   32'(bus.last_coeff),   32'd0);
    tick();
    tick();
    n_rst = 1'b1;

    // control pulses before any fill must be ignored
    pulse_request();
    check("early_request_dv", 32'(bus.data_valid), 32'd0);

    // back-to-back fill: pixels 1..16 then coeffs A0..A7
    for (int i = 0; i < 24; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = (i < 16) ? 8'(i + 1) : 8'(8'hA0 + (i - 16));
      if (i == 23) check("fill_ready_beat24", 32'(bus.rx_ready), 32'd1);
      if (i == 23) check("fill_loaded_beat24", 32'(bus.image_loaded), 32'd0);
      tick();
    end
    check("fill_ready_drop", 32'(bus.rx_ready),     32'd0);
    check("fill_loaded",     32'(bus.image_loaded), 32'd1);

    // junk while LOADED must not be written
    bus.rx_data = 8'hFF;
    tick();
    tick();
    bus.rx_valid = 1'b0;
    check("loaded_hold", 32'(bus.image_loaded), 32'd1);
    check("loaded_dv",   32'(bus.data_valid),   32'd0);

    pulse_request();
    check("serve_dv",     32'(bus.data_valid),   32'd1);
    check("serve_loaded", 32'(bus.image_loaded), 32'd0);
    check("serve_pix0",   32'(bus.pixel_out),    32'd1);
    check("serve_coeff0", 32'(bus.coeff_out),    32'hA0);
    check("serve_lastp0", 32'(bus.last_pixel),   32'd0);

    for (int i = 0; i < 15; i++) pulse_adv(1'b1, 1'b0, 1'b0);
    check("pix15",       32'(bus.pixel_out),  32'd16);
    check("last_pix15",  32'(bus.last_pixel), 32'd1);
    check("coeff_still", 32'(bus.coeff_out),  32'hA0);
    pulse_adv(1'b1, 1'b0, 1'b0);
    check("pix_wrap",      32'(bus.pixel_out),  32'd1);
    check("last_pix_wrap", 32'(bus.last_pixel), 32'd0);

    for (int i = 0; i < 7; i++) pulse_adv(1'b0, 1'b1, 1'b0);
    check("coeff7",      32'(bus.coeff_out),  32'hA7);
    check("last_coeff7", 32'(bus.last_coeff), 32'd1);
    check("pix_hold",    32'(bus.pixel_out),  32'd1);

    pulse_adv(1'b1, 1'b1, 1'b0);
    check("both_coeff_wrap", 32'(bus.coeff_out),  32'hA0);
    check("both_last_coeff", 32'(bus.last_coeff), 32'd0);
    check("both_pix_adv",    32'(bus.pixel_out),  32'd2);

    // done beats load_next
    pulse_adv(1'b1, 1'b0, 1'b1);
    check("done_dv",       32'(bus.data_valid),   32'd0);
    check("done_pix",      32'(bus.pixel_out),    32'd0);
    check("done_coeff",    32'(bus.coeff_out),    32'd0);
    check("done_rx_ready", 32'(bus.rx_ready),     32'd1);
    check("done_loaded",   32'(bus.image_loaded), 32'd0);
    pulse_request();
    check("done_req_ignored", 32'(bus.data_valid), 32'd0);

    // gapped refill: pixels 0x10.., coeffs 0xB0..
    accepted = 0;
    cyc = 0;
    while (accepted < 24 && cyc < 200) begin
      bus.rx_valid = ((cyc % 3) != 1);
      bus.rx_data  = (accepted < 16) ? 8'(8'h10 + accepted) : 8'(8'hB0 + (accepted - 16));
      if (accepted == 23 && bus.rx_valid) check("gap_loaded_23", 32'(bus.image_loaded), 32'd0);
      tick();
      if (bus.rx_valid) accepted++;
      cyc++;
    end
    bus.rx_valid = 1'b0;
    check("gap_accepted", 32'(accepted), 32'd24);
    check("gap_loaded",   32'(bus.image_loaded), 32'd1);

    pulse_request();
    check("gap_pix0",   32'(bus.pixel_out), 32'h10);
    check("gap_coeff0", 32'(bus.coeff_out), 32'hB0);
    for (int i = 0; i < 3; i++) pulse_adv(1'b1, 1'b1, 1'b0);
    check("gap_pix3",   32'(bus.pixel_out), 32'h13);
    check("gap_coeff3", 32'(bus.coeff_out), 32'hB3);

    // asynchronous reset between edges
    #3;
    n_rst = 1'b0;
    #1;
    check("arst_dv",       32'(bus.data_valid),   32'd0);
    check("arst_pix",      32'(bus.pixel_out),    32'd0);
    check("arst_coeff",    32'(bus.coeff_out),    32'd0);
    check("arst_lastc",    32'(bus.last_coeff),   32'd0);
    check("arst_rx_ready", 32'(bus.rx_ready),     32'd1);
    check("arst_loaded",   32'(bus.image_loaded), 32'd0);
    tick();
    n_rst = 1'b1;

    // partial refill must not report loaded
    for (int i = 0; i < 10; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'(i);
      tick();
    end
    bus.rx_valid = 1'b0;
    check("partial_loaded", 32'(bus.image_loaded), 32'd0);
    pulse_request();
    check("partial_req_dv", 32'(bus.data_valid), 32'd0);
    check("partial_ready",  32'(bus.rx_ready),   32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
